// File: rtl/sm_batch_scheduler.sv
// -----------------------------------------------------------------------------
// sm_batch_scheduler
//   Sequences one batch of target records into SM_feeder and collects the
//   matching scores from ScoringModule_v1.
//   - Pulls records from an upstream valid/ready source and issues a one-cycle
//     ld pulse with the record on feed_in. A record is only pulled while the
//     feeder is not full, and never in the cycle right after a load.
//   - Captures rising edges of the two toggle result lanes into one-entry
//     holds. A round-robin arbiter merges the holds into one valid/ready
//     stream.
//   - Pulses done once every issued target has been retired downstream.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start, num_seqs     batch start pulse and target count (taken in IDLE only)
//   src_valid/ready/data  upstream record stream; src_ready is combinational
//   full, ld, feed_in   SM_feeder interface
//   vld0/1, result0/1, id0/1  ScoringModule result lanes
//   res_valid/ready/id/score  merged result stream
//   busy, done, overflow  status: in batch, completion pulse, sticky lost result
//
// Configuration macro: SM_SCHED_ID_REMAP_EN
//   When defined, the ID field of feed_in is replaced by the zero-extended
//   issue index (0..total-1). When undefined, src_data passes through unchanged.
// -----------------------------------------------------------------------------
module sm_batch_scheduler #(
    parameter int TARGET_LENGTH = 128,
    parameter int ID_WIDTH      = 48,
    parameter int LEN_WIDTH     = 12,
    parameter int SCORE_WIDTH   = 12,
    parameter int CNT_WIDTH     = 16,
    parameter int IN_WIDTH      = ID_WIDTH + LEN_WIDTH + 2 * TARGET_LENGTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CNT_WIDTH-1:0]   num_seqs,
    input  logic                   src_valid,
    output logic                   src_ready,
    input  logic [IN_WIDTH-1:0]    src_data,
    input  logic                   full,
    output logic                   ld,
    output logic [IN_WIDTH-1:0]    feed_in,
    input  logic                   vld0,
    input  logic                   vld1,
    input  logic [SCORE_WIDTH-1:0] result0,
    input  logic [SCORE_WIDTH-1:0] result1,
    input  logic [ID_WIDTH-1:0]    id0,
    input  logic [ID_WIDTH-1:0]    id1,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [ID_WIDTH-1:0]    res_id,
    output logic [SCORE_WIDTH-1:0] res_score,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e                          state_q, state_d;
    logic [CNT_WIDTH-1:0]            total_q, total_d;
    logic [CNT_WIDTH-1:0]            issued_q, issued_d;
    logic [CNT_WIDTH-1:0]            retired_q, retired_d;
    logic                            ld_q, ld_d;
    logic [IN_WIDTH-1:0]             feed_in_q, feed_in_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
    logic                            overflow_q, overflow_d;
    logic [1:0]                      vld_prev_q, vld_prev_d;
    logic [1:0]                      hold_full_q, hold_full_d;
    logic [1:0][ID_WIDTH-1:0]        hold_id_q, hold_id_d;
    logic [1:0][SCORE_WIDTH-1:0]     hold_score_q, hold_score_d;
    logic                            res_valid_q, res_valid_d;
    logic [ID_WIDTH-1:0]             res_id_q, res_id_d;
    logic [SCORE_WIDTH-1:0]          res_score_q, res_score_d;
    logic                            rr_q, rr_d;

    logic                            src_ready_s;
    logic                            accept_s;
    logic                            out_free_s;
    logic [1:0]                      grant_s;
    logic [1:0]                      lane_vld_s;
    logic [1:0][ID_WIDTH-1:0]        lane_id_s;
    logic [1:0][SCORE_WIDTH-1:0]     lane_score_s;

    assign lane_vld_s   = {vld1, vld0};
    assign lane_id_s    = {id1, id0};
    assign lane_score_s = {result1, result0};

    // Next-state, handshake, capture and arbitration logic.
    always_comb begin
        state_d      = state_q;
        total_d      = total_q;
        issued_d     = issued_q;
        retired_d    = retired_q;
        ld_d         = 1'b0;
        feed_in_d    = feed_in_q;
        overflow_d   = overflow_q;
        vld_prev_d   = lane_vld_s;
        hold_full_d  = hold_full_q;
        hold_id_d    = hold_id_q;
        hold_score_d = hold_score_q;
        res_valid_d  = res_valid_q;
        res_id_d     = res_id_q;
        res_score_d  = res_score_q;
        rr_d         = rr_q;

        // The !ld_q term leaves one cycle for full to reflect the last load.
        src_ready_s = (state_q == ST_LOAD) && !full && !ld_q && (issued_q < total_q);
        accept_s    = src_valid && src_ready_s;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    total_d    = num_seqs;
                    issued_d   = {CNT_WIDTH{1'b0}};
                    retired_d  = {CNT_WIDTH{1'b0}};
                    overflow_d = 1'b0;
                    if (num_seqs != {CNT_WIDTH{1'b0}}) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (accept_s) begin
                    ld_d     = 1'b1;
                    issued_d = issued_q + CNT_WIDTH'(1);
`ifdef SM_SCHED_ID_REMAP_EN
                    feed_in_d = {ID_WIDTH'(issued_q), src_data[IN_WIDTH-ID_WIDTH-1:0]};
`else
                    feed_in_d = src_data;
`endif
                end else begin
                    ld_d = 1'b0;
                end
                if (issued_q == total_q) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_DRAIN: begin
                if ((retired_q == total_q) && (hold_full_q == 2'b00) && !res_valid_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Only in-batch results count; extras beyond total are forwarded uncounted.
        if (res_valid_q && res_ready && (state_q == ST_LOAD || state_q == ST_DRAIN)
            && (retired_q < total_q)) begin
            retired_d = retired_q + CNT_WIDTH'(1);
        end else begin
            retired_d = retired_d;
        end

        // Output register accepts new data when empty or being consumed.
        out_free_s = !res_valid_q || res_ready;
        if (!out_free_s) begin
            grant_s = 2'b00;
        end else if (hold_full_q == 2'b11) begin
            grant_s = rr_q ? 2'b10 : 2'b01;
        end else begin
            grant_s = hold_full_q;
        end

        if (out_free_s) begin
            res_valid_d = |grant_s;
        end else begin
            res_valid_d = res_valid_q;
        end
        if (grant_s[1]) begin
            res_id_d    = hold_id_q[1];
            res_score_d = hold_score_q[1];
            rr_d        = !rr_q;
        end else if (grant_s[0]) begin
            res_id_d    = hold_id_q[0];
            res_score_d = hold_score_q[0];
            rr_d        = !rr_q;
        end else begin
            rr_d = rr_q;
        end

        // A hold granted this cycle is free again, so a same-cycle edge lands in it.
        for (int i = 0; i < 2; i++) begin
            hold_full_d[i] = hold_full_q[i] && !grant_s[i];
            if (lane_vld_s[i] && !vld_prev_q[i]) begin
                if (!hold_full_q[i] || grant_s[i]) begin
                    hold_full_d[i]  = 1'b1;
                    hold_id_d[i]    = lane_id_s[i];
                    hold_score_d[i] = lane_score_s[i];
                end else begin
                    overflow_d = 1'b1;
                end
            end else begin
                hold_id_d[i] = hold_id_q[i];
            end
        end

        busy_d = (state_d == ST_LOAD) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            total_q      <= {CNT_WIDTH{1'b0}};
            issued_q     <= {CNT_WIDTH{1'b0}};
            retired_q    <= {CNT_WIDTH{1'b0}};
            ld_q         <= 1'b0;
            feed_in_q    <= {IN_WIDTH{1'b0}};
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
            vld_prev_q   <= 2'b00;
            hold_full_q  <= 2'b00;
            hold_id_q    <= '0;
            hold_score_q <= '0;
            res_valid_q  <= 1'b0;
            res_id_q     <= {ID_WIDTH{1'b0}};
            res_score_q  <= {SCORE_WIDTH{1'b0}};
            rr_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            total_q      <= total_d;
            issued_q     <= issued_d;
            retired_q    <= retired_d;
            ld_q         <= ld_d;
            feed_in_q    <= feed_in_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            overflow_q   <= overflow_d;
            vld_prev_q   <= vld_prev_d;
            hold_full_q  <= hold_full_d;
            hold_id_q    <= hold_id_d;
            hold_score_q <= hold_score_d;
            res_valid_q  <= res_valid_d;
            res_id_q     <= res_id_d;
            res_score_q  <= res_score_d;
            rr_q         <= rr_d;
        end
    end

    assign src_ready = src_ready_s;
    assign ld        = ld_q;
    assign feed_in   = feed_in_q;
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_score = res_score_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_sm_batch_scheduler.sv
// Bench for sm_batch_scheduler: directed scenarios plus randomized batches
// checked against an in-order scoreboard of records and results.
module tb_sm_batch_scheduler;

    localparam int TL   = 128;
    localparam int ID_W = 48;
    localparam int LN_W = 12;
    localparam int SC_W = 12;
    localparam int CN_W = 16;
    localparam int IN_W = ID_W + LN_W + 2 * TL;

    logic             clk = 1'b0;
    logic             rst, start, src_valid, full, vld0, vld1, res_ready;
    logic [CN_W-1:0]  num_seqs;
    logic [IN_W-1:0]  src_data;
    logic [SC_W-1:0]  result0, result1;
    logic [ID_W-1:0]  id0, id1;
    logic             src_ready, ld, res_valid, busy, done, overflow;
    logic [IN_W-1:0]  feed_in;
    logic [ID_W-1:0]  res_id;
    logic [SC_W-1:0]  res_score;

    int n_cmp = 0;
    int n_bad = 0;

    sm_batch_scheduler #(.TARGET_LENGTH(TL), .ID_WIDTH(ID_W), .LEN_WIDTH(LN_W),
                         .SCORE_WIDTH(SC_W), .CNT_WIDTH(CN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .num_seqs(num_seqs),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .full(full), .ld(ld), .feed_in(feed_in),
        .vld0(vld0), .vld1(vld1), .result0(result0), .result1(result1),
        .id0(id0), .id1(id1),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_score(res_score),
        .busy(busy), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; start = 1'b0; num_seqs = '0; src_valid = 1'b0; src_data = '0;
        full = 1'b0; vld0 = 1'b0; vld1 = 1'b0; result0 = '0; result1 = '0;
        id0 = '0; id1 = '0; res_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [IN_W-1:0] rand_rec();
        logic [IN_W-1:0] r;
        r = '0;
        for (int k = 0; k < 10; k++) r = (r << 32) | IN_W'($urandom());
        return r;
    endfunction

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if ({ld, src_ready, res_valid, busy, done, overflow} !== 6'b000000) begin
            n_bad++; $display("FAIL reset_ctrl: got %b want 000000", {ld, src_ready, res_valid, busy, done, overflow});
        end
        n_cmp++;
        if (feed_in !== '0) begin n_bad++; $display("FAIL reset_feed_in: got %h want 0", feed_in); end
        n_cmp++;
        if ({res_id, res_score} !== '0) begin n_bad++; $display("FAIL reset_res: got %h want 0", {res_id, res_score}); end
    endtask

    task automatic test_issue();
        int ld_cyc[$];
        apply_reset();
        src_valid = 1'b1; src_data = rand_rec();
        start = 1'b1; num_seqs = 16'd3;
        tick();
        start = 1'b0;
        for (int c = 0; c < 14; c++) begin
            tick();
            if (ld) ld_cyc.push_back(c);
            n_cmp++;
            if (busy !== 1'b1) begin n_bad++; $display("FAIL issue_busy: cycle %0d got %b want 1", c, busy); end
        end
        n_cmp++;
        if (ld_cyc.size() != 3) begin n_bad++; $display("FAIL issue_ld_count: got %0d want 3", ld_cyc.size()); end
        for (int i = 1; i < ld_cyc.size(); i++) begin
            n_cmp++;
            if (ld_cyc[i] - ld_cyc[i-1] < 2) begin
                n_bad++; $display("FAIL issue_ld_adjacent: gap %0d want >=2", ld_cyc[i] - ld_cyc[i-1]);
            end
        end
    endtask

    task automatic test_full_throttle();
        bit seen = 1'b0;
        apply_reset();
        src_valid = 1'b1; src_data = rand_rec(); full = 1'b1;
        start = 1'b1; num_seqs = 16'd2;
        tick();
        start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_cmp++;
            if (src_ready !== 1'b0 || ld !== 1'b0) begin
                n_bad++; $display("FAIL full_stall: cycle %0d src_ready=%b ld=%b want 0/0", c, src_ready, ld);
            end
        end
        full = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (ld) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin n_bad++; $display("FAIL full_resume: no ld within 6 cycles after full=0, want ld"); end
    endtask

    task automatic test_dual_lane();
        logic [ID_W+SC_W-1:0] got[$];
        apply_reset();
        res_ready = 1'b1;
        vld0 = 1'b1; id0 = 48'd5; result0 = 12'h0A5;
        vld1 = 1'b1; id1 = 48'd6; result1 = 12'hF36;
        tick();
        vld0 = 1'b0; vld1 = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (res_valid) got.push_back({res_id, res_score});
        end
        n_cmp++;
        if (got.size() != 2) begin
            n_bad++; $display("FAIL dual_count: got %0d outputs want 2", got.size());
        end else begin
            n_cmp++;
            if (got[0] !== {48'd5, 12'h0A5}) begin n_bad++; $display("FAIL dual_first: got %h want lane0 id 5", got[0]); end
            n_cmp++;
            if (got[1] !== {48'd6, 12'hF36}) begin n_bad++; $display("FAIL dual_second: got %h want lane1 id 6", got[1]); end
        end
    endtask

    task automatic test_overflow();
        logic [ID_W-1:0] got[$];
        apply_reset();
        res_ready = 1'b0;
        for (int p = 1; p <= 3; p++) begin
            vld0 = 1'b1; id0 = ID_W'(p); result0 = SC_W'(p * 7);
            tick();
            vld0 = 1'b0;
            tick();
            if (p == 2) begin
                n_cmp++;
                if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_early: got %b want 0", overflow); end
            end
        end
        n_cmp++;
        if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %b want 1", overflow); end
        n_cmp++;
        if (res_valid !== 1'b1 || res_id !== 48'd1) begin
            n_bad++; $display("FAIL ovf_hold_out: valid=%b id=%0d want 1/1", res_valid, res_id);
        end
        res_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (res_valid) got.push_back(res_id);
            tick();
        end
        n_cmp++;
        if (got.size() != 2 || got[0] !== 48'd1 || got[1] !== 48'd2) begin
            n_bad++; $display("FAIL ovf_drain: got %0d items (want ids 1,2)", got.size());
        end
        n_cmp++;
        if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_zero();
        start = 1'b1; num_seqs = 16'd0;
        tick();
        start = 1'b0;
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL zero_done: done=%b busy=%b want 1/0", done, busy); end
        n_cmp++;
        if (overflow !== 1'b0) begin n_bad++; $display("FAIL zero_ovf_clear: got %b want 0", overflow); end
        tick();
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL zero_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_random_batch(input int n);
        logic [IN_W-1:0]      exp_q[$];
        logic [ID_W+SC_W-1:0] res_q[$];
        logic [IN_W-1:0]      rec, want;
        logic [ID_W+SC_W-1:0] r;
        int lds = 0, sent = 0, got = 0, cyc = 0, idx = 0;
        bit prev_ld = 1'b0, seen_done = 1'b0;
        apply_reset();
        start = 1'b1; num_seqs = CN_W'(n);
        tick();
        start = 1'b0;
        while (cyc < 3000 && !seen_done) begin
            src_valid = ($urandom_range(0, 3) != 0);
            src_data  = rand_rec();
            full      = ($urandom_range(0, 4) == 0);
            res_ready = ($urandom_range(0, 2) != 0);
            vld0 = 1'b0; vld1 = 1'b0;
            if (sent < lds && res_q.size() == 0) begin
                r = {ID_W'($urandom()), SC_W'($urandom())};
                if ($urandom_range(0, 1) == 0) begin
                    vld0 = 1'b1; {id0, result0} = r;
                end else begin
                    vld1 = 1'b1; {id1, result1} = r;
                end
                res_q.push_back(r);
                sent++;
            end
            #1;
            n_cmp++;
            if (full && src_ready) begin n_bad++; $display("FAIL rnd_ready_full: src_ready=1 while full, want 0"); end
            if (src_valid && src_ready) begin
                rec = src_data;
`ifdef SM_SCHED_ID_REMAP_EN
                rec[IN_W-1 -: ID_W] = ID_W'(idx);
`endif
                exp_q.push_back(rec);
                idx++;
            end
            if (res_valid && res_ready) begin
                n_cmp++;
                if (res_q.size() == 0) begin
                    n_bad++; $display("FAIL rnd_res_extra: unexpected result %h", {res_id, res_score});
                end else begin
                    r = res_q.pop_front();
                    if ({res_id, res_score} !== r) begin
                        n_bad++; $display("FAIL rnd_res_data: got %h want %h", {res_id, res_score}, r);
                    end
                end
                got++;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (ld) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL rnd_ld_extra: ld with no accepted record");
                end else begin
                    want = exp_q.pop_front();
                    if (feed_in !== want || prev_ld) begin
                        n_bad++; $display("FAIL rnd_feed: feed_in %h prev_ld %b want %h prev_ld 0", feed_in, prev_ld, want);
                    end
                end
                lds++;
            end
            prev_ld = ld;
            if (done) begin
                seen_done = 1'b1;
                n_cmp++;
                if (got != n || lds != n || busy !== 1'b0 || cyc < 2 * n + 2) begin
                    n_bad++; $display("FAIL rnd_done: n=%0d retired=%0d lds=%0d busy=%b latency=%0d want %0d/%0d/0/>=%0d",
                                      n, got, lds, busy, cyc, n, n, 2 * n + 2);
                end
            end
        end
        n_cmp++;
        if (!seen_done) begin n_bad++; $display("FAIL rnd_timeout: no done for n=%0d within 3000 cycles", n); end
        vld0 = 1'b0; vld1 = 1'b0;
        tick();
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL rnd_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_rst_mid_load();
        apply_reset();
        src_valid = 1'b1; src_data = rand_rec();
        start = 1'b1; num_seqs = 16'd5;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({busy, ld, src_ready, res_valid} !== 4'b0000) begin
            n_bad++; $display("FAIL rst_abort: busy/ld/src_ready/res_valid got %b want 0000", {busy, ld, src_ready, res_valid});
        end
        for (int c = 0; c < 6; c++) begin
            tick();
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_bad++; $display("FAIL rst_no_done: cycle %0d done=%b busy=%b want 0/0", c, done, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_issue();
        test_full_throttle();
        test_dual_lane();
        test_overflow();
        test_zero();
        test_random_batch(2);
        for (int b = 0; b < 6; b++) test_random_batch(int'($urandom_range(1, 7)));
        test_rst_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
